// File: rtl/ham_scrubber_if.sv
// Single-port memory bus between the scrubber (master) and the protected memory (slave).
// Codewords are carried as [15:1] so bit indices match Hamming positions.
interface ham_scrubber_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [15:1]       mem_rdata;
    logic              mem_we;
    logic [15:1]       mem_wdata;

    modport master (
        output mem_addr,
        output mem_re,
        input  mem_rdata,
        output mem_we,
        output mem_wdata
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        output mem_rdata,
        input  mem_we,
        input  mem_wdata
    );
endinterface

// File: rtl/ham_scrubber.sv
// Background Hamming(15,11) scrubber: sweeps addresses 0..DEPTH-1, fixes single-bit errors in place.
// Optional error log (last_err_addr / last_syndrome) enabled by defining HAM_SCRUB_LOG_EN.
module ham_scrubber #(
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    last_err_addr,
    output logic [3:0]           last_syndrome,
    output logic [2:0]           dbg_state,
    ham_scrubber_if.master       mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CHECK, S_WRITE, S_DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [ERR_CNT_W-1:0]  err_q;
    logic [3:0]            syn_q;
    logic [15:1]           corr_q;
    logic [15:1]           wdata_q;
    logic                  busy_q, done_q, aborted_q, re_q, we_q, abort_seen_q;

    logic [3:0]            syn_d;
    logic [15:1]           corr_d;
    logic                  boundary, last_word, abort_hit;

    // Syndrome is the XOR of the indices of all set bits; nonzero names the flipped bit.
    always_comb begin
        syn_d  = '0;
        corr_d = mem.mem_rdata;
        for (int i = 1; i <= 15; i++) begin
            if (mem.mem_rdata[i]) syn_d = syn_d ^ 4'(i);
        end
        for (int i = 1; i <= 15; i++) begin
            if (syn_d == 4'(i)) corr_d[i] = ~mem.mem_rdata[i];
        end
    end

    assign boundary  = (state_q == S_WRITE) || (state_q == S_CHECK && syn_q == 4'd0);
    assign last_word = (addr_q == ADDR_W'(DEPTH - 1));
    assign abort_hit = abort_seen_q | abort;

    // Control handshake: start is sampled only in IDLE (wins over abort there); abort is
    // latched while busy and acted on at the next word boundary, after any pending write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            err_q        <= '0;
            syn_q        <= '0;
            corr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            abort_seen_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            if (state_q != S_IDLE && abort) abort_seen_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_READ;
                        addr_q       <= '0;
                        err_q        <= '0;
                        busy_q       <= 1'b1;
                        re_q         <= 1'b1;
                        abort_seen_q <= 1'b0;
                    end
                end
                S_READ:  state_q <= S_WAIT;
                S_WAIT: begin
                    syn_q   <= syn_d;
                    corr_q  <= corr_d;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (syn_q != 4'd0) begin
                        if (err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
                        we_q    <= 1'b1;
                        wdata_q <= corr_q;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: state_q <= S_WRITE;
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (boundary) begin
                abort_seen_q <= 1'b0;
                if (abort_hit) begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    aborted_q <= 1'b1;
                end else if (last_word) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    re_q    <= 1'b1;
                    state_q <= S_READ;
                end
            end
        end
    end

`ifdef HAM_SCRUB_LOG_EN
    logic [ADDR_W-1:0] log_addr_q;
    logic [3:0]        log_syn_q;

    // Log survives across sweeps; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            log_addr_q <= '0;
            log_syn_q  <= '0;
        end else if (state_q == S_CHECK && syn_q != 4'd0) begin
            log_addr_q <= addr_q;
            log_syn_q  <= syn_q;
        end
    end

    assign last_err_addr = log_addr_q;
    assign last_syndrome = log_syn_q;
`else
    assign last_err_addr = '0;
    assign last_syndrome = '0;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign err_count     = err_q;
    assign dbg_state     = state_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_re    = re_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_ham_scrubber.sv
// Bench for ham_scrubber: word-level sweep model drives a per-cycle expected trace,
// plus literal checks for cycle counts, saturation, abort, reset and DEPTH=1.
module tb_ham_scrubber;

  localparam int ERR_MAX = 7;  // main DUT uses ERR_CNT_W=3

  logic clk = 1'b0;
  logic reset_n, start, abort, start1;
  always #5 clk = ~clk;

  // main DUT: DEPTH=16, ERR_CNT_W=3
  logic       busy, done, aborted;
  logic [2:0] err_count;
  logic [3:0] last_err_addr, last_syndrome;
  logic [2:0] dbg_state;
  ham_scrubber_if #(.ADDR_W(4)) bus ();

  ham_scrubber #(.ADDR_W(4), .DEPTH(16), .ERR_CNT_W(3)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .err_count(err_count),
    .last_err_addr(last_err_addr), .last_syndrome(last_syndrome),
    .dbg_state(dbg_state), .mem(bus)
  );

  // second DUT: DEPTH=1
  logic       busy1, done1, aborted1;
  logic [7:0] err_count1;
  logic [3:0] last_err_addr1, last_syndrome1;
  logic [2:0] dbg_state1;
  ham_scrubber_if #(.ADDR_W(4)) bus1 ();

  ham_scrubber #(.ADDR_W(4), .DEPTH(1), .ERR_CNT_W(8)) dut1 (
    .clock(clk), .reset_n(reset_n), .start(start1), .abort(1'b0),
    .busy(busy1), .done(done1), .aborted(aborted1), .err_count(err_count1),
    .last_err_addr(last_err_addr1), .last_syndrome(last_syndrome1),
    .dbg_state(dbg_state1), .mem(bus1)
  );

  // memories and bookkeeping
  logic [15:1] mem [16];
  logic [15:1] mem1;
  int          n_wr;

  logic [15:1] clean_tab [16] = '{
    15'h0000, 15'h0007, 15'h0034, 15'h2140, 15'h408B, 15'h7FFF, 15'h0888, 15'h4210,
    15'h4120, 15'h4804, 15'h1420, 15'h6001, 15'h0007, 15'h0034, 15'h0888, 15'h7FFF
  };

  // model state
  logic [23:0] exp_q [$];
  logic [15:1] exp_mem [16];
  int          exp_err;
  logic [3:0]  exp_hold, exp_last_addr, exp_last_syn;

  int n_vec, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // parity check k covers every position whose index has bit k set
  function automatic logic [3:0] syn_of(input logic [15:1] w);
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      int ones;
      ones = 0;
      for (int i = 1; i <= 15; i++) if (((i >> k) & 1) == 1 && w[i]) ones++;
      s[k] = ((ones % 2) == 1);
    end
    return s;
  endfunction

  function automatic void push(input logic b, r, w, d, a, input logic [3:0] ad,
                               input logic [15:1] wd);
    exp_q.push_back({b, r, w, d, a, ad, wd});
  endfunction

  // kind 0: full sweep; 1: abort takes effect after word stop; 2: reset during WAIT of word stop
  task automatic plan(input int kind, input int stop);
    logic [3:0]  s;
    logic [15:1] corr;
    push(0, 0, 0, 0, 0, exp_hold, '0);
    exp_err = 0;
    for (int a = 0; a < 16; a++) begin
      push(1, 1, 0, 0, 0, 4'(a), '0);
      if (kind == 2 && a == stop) return;
      push(1, 0, 0, 0, 0, 4'(a), '0);
      push(1, 0, 0, 0, 0, 4'(a), '0);
      s = syn_of(exp_mem[a]);
      if (s != 4'd0) begin
        corr = exp_mem[a];
        corr[s] = ~corr[s];
        push(1, 0, 1, 0, 0, 4'(a), corr);
        exp_mem[a] = corr;
        if (exp_err < ERR_MAX) exp_err++;
        exp_last_addr = 4'(a);
        exp_last_syn  = s;
      end
      exp_hold = 4'(a);
      if (kind == 1 && a == stop) begin
        push(0, 0, 0, 0, 1, 4'(a), '0);
        push(0, 0, 0, 0, 0, 4'(a), '0);
        return;
      end
    end
    push(1, 0, 0, 1, 0, 4'd15, '0);
    push(0, 0, 0, 0, 0, 4'd15, '0);
  endtask

  task automatic load_clean();
    for (int a = 0; a < 16; a++) begin
      mem[a]     = clean_tab[a];
      exp_mem[a] = clean_tab[a];
    end
  endtask

  task automatic flip(input int a, input int b);
    mem[a][b]     = ~mem[a][b];
    exp_mem[a][b] = ~exp_mem[a][b];
  endtask

  task automatic kick(input logic ab, input int kind, input int stop);
    @(posedge clk); #1;
    start = 1'b1;
    abort = ab;
    plan(kind, stop);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && aborted !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    chk("trace_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_bus(input logic want_we, input logic [3:0] ad);
    int t;
    t = 0;
    while (!(((want_we ? bus.mem_we : bus.mem_re) === 1'b1) && bus.mem_addr === ad) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bus_event_seen", (t < 200), 1);
  endtask

  initial begin
    int cyc, wr0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    n_vec = 0; n_fail = 0; n_wr = 0;
    exp_err = 0; exp_hold = '0; exp_last_addr = '0; exp_last_syn = '0;
    mem1 = 15'h0034;
    bus.mem_rdata = '0;
    bus1.mem_rdata = '0;
    load_clean();

    fork
      // synchronous single-port memories: read data one cycle after mem_re
      forever begin
        @(posedge clk);
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) begin
          mem[bus.mem_addr] <= bus.mem_wdata;
          n_wr++;
        end
        if (bus1.mem_re) bus1.mem_rdata <= mem1;
        if (bus1.mem_we) mem1 <= bus1.mem_wdata;
      end
      // per-cycle trace compare against the model
      forever begin
        logic [23:0] e, a;
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = {busy, bus.mem_re, bus.mem_we, done, aborted, bus.mem_addr,
               (bus.mem_we ? bus.mem_wdata : 15'h0000)};
          n_vec++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL trace t=%0t: got b/re/we/dn/ab/addr/wd=%h, want %h", $time, a, e);
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, aborted, bus.mem_re, bus.mem_we}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_err", err_count, 0);
    chk("rst_log", {last_err_addr, last_syndrome}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: clean sweep
    wr0 = n_wr;
    kick(1'b0, 0, 0);
    wait_end(cyc);
    chk("t1_done_cycle", cyc, 49);
    drain();
    chk("t1_writes", n_wr - wr0, 0);
    chk("t1_err", err_count, exp_err);
    chk("t1_err_lit", err_count, 0);

    // 2: single flipped bit 6 in word 5
    flip(5, 6);
    chk("t2_corrupt_lit", mem[5], 15'h7FDF);
    wr0 = n_wr;
    kick(1'b0, 0, 0);
    wait_end(cyc);
    chk("t2_done_cycle", cyc, 50);
    drain();
    chk("t2_writes", n_wr - wr0, 1);
    chk("t2_fixed_lit", mem[5], 15'h7FFF);
    chk("t2_err_lit", err_count, 1);
`ifdef HAM_SCRUB_LOG_EN
    chk("t2_log_syn", last_syndrome, 6);
    chk("t2_log_addr", last_err_addr, 5);
`else
    chk("t2_log_off", {last_err_addr, last_syndrome}, 0);
`endif

    // 3: errors everywhere, counter saturates
    for (int a = 0; a < 16; a++) flip(a, (a % 15) + 1);
    wr0 = n_wr;
    kick(1'b0, 0, 0);
    wait_end(cyc);
    chk("t3_done_cycle", cyc, 65);
    drain();
    chk("t3_writes", n_wr - wr0, 16);
    chk("t3_err_sat", err_count, 7);
    chk("t3_err_model", err_count, exp_err);
    for (int a = 0; a < 16; a++) chk("t3_mem", mem[a], exp_mem[a]);
`ifdef HAM_SCRUB_LOG_EN
    chk("t3_log", {last_err_addr, last_syndrome}, {exp_last_addr, exp_last_syn});
`endif

    // 4: abort during WRITE of addr 3
    load_clean();
    flip(3, 2);
    flip(6, 1);
    kick(1'b0, 1, 3);
    wait_bus(1'b1, 4'd3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();
    chk("t4_busy", busy, 0);
    chk("t4_fixed3", mem[3], 15'h2140);
    chk("t4_untouched6", mem[6], 15'h0889);
    chk("t4_err", err_count, 1);

    // 4b: abort during READ of a clean word is held until that word's boundary
    load_clean();
    kick(1'b0, 1, 2);
    wait_bus(1'b0, 4'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();
    chk("t4b_err_hold", err_count, 0);

    // 5: reset during WAIT of addr 7, then full restart
    load_clean();
    flip(7, 3);
    kick(1'b0, 2, 7);
    wait_bus(1'b0, 4'd7);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_pulses", {done, aborted, bus.mem_re, bus.mem_we}, 0);
    chk("t5_addr", bus.mem_addr, 0);
    chk("t5_wdata", bus.mem_wdata, 0);
    chk("t5_err", err_count, 0);
    chk("t5_log", {last_err_addr, last_syndrome}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_we", bus.mem_we, 0);
    end
    reset_n = 1'b1;
    exp_q.delete();
    exp_hold = '0; exp_last_addr = '0; exp_last_syn = '0;
    chk("t5_word7_kept", mem[7], 15'h4214);
    kick(1'b0, 0, 0);
    drain();
    chk("t5_word7_fixed", mem[7], 15'h4210);
    chk("t5_err_after", err_count, 1);

    // 6: abort in IDLE ignored; start+abort together starts; start while busy ignored
    load_clean();
    flip(10, 9);
    @(posedge clk); #1;
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t6_idle_abort", {busy, aborted}, 0);
    kick(1'b1, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    chk("t6_err", err_count, 1);
    chk("t6_fixed", mem[10], 15'h1420);

    // 6b: DEPTH=1 instance, clean then corrupted
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("d1_read", {busy1, bus1.mem_re}, 2'b11);
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("d1_done_cycle", cyc, 4);
    chk("d1_addr", bus1.mem_addr, 0);
    @(posedge clk); #1;
    chk("d1_idle", {busy1, done1}, 0);
    chk("d1_err", err_count1, 0);
    mem1 = 15'h0035;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("d1e_done_cycle", cyc, 5);
    @(posedge clk); #1;
    chk("d1e_err", err_count1, 1);
    chk("d1e_fixed", mem1, 15'h0034);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
